// File: rtl/isa_word_encoder.sv
// ---------------------------------------------------------------------------
// isa_word_encoder
//
// Write side of the 16-bit Unicycle instruction format. Symbolic instructions
// (opcode index, register fields, immediate) arrive over a valid/ready
// handshake. Each one is range-checked, packed into a 16-bit word and written
// to instruction memory at a byte address that advances by 2 per word. The
// boot/debug path uses this block to load programs.
//
// Optional feature macro: ISA_ENC_PSEUDO_LI_EN
//   defined   : op 32 (LI) expands to an LU word followed by an LL word.
//   undefined : op 32 is illegal, and the LI_LO state is not built.
//
// Parameters
//   ADDR_W      instruction-memory byte-address width
//   START_ADDR  address loaded on reset and on start (must be even)
//
// Ports
//   clk         clock
//   rst_n       synchronous active-low reset
//   start       restart load: address to START_ADDR, clear errors and count
//   in_valid    instruction request valid
//   in_ready    request accepted on an edge with in_valid && in_ready
//   in_op       opcode index (0-7 ALU ... 28-31 compares, 32 LI, 33+ illegal)
//   in_ra/rb/rc register fields
//   in_imm      immediate (signed or unsigned depending on op)
//   mem_we      one-cycle write strobe per word
//   mem_addr    byte address of mem_wdata
//   mem_wdata   encoded instruction word
//   err_illegal sticky: illegal in_op accepted
//   err_range   sticky: immediate out of field range
//   word_count  words written since reset/start, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module isa_word_encoder #(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [2:0]        in_ra,
  input  logic [2:0]        in_rb,
  input  logic [2:0]        in_rc,
  input  logic [15:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              err_illegal,
  output logic              err_range,
  output logic [15:0]       word_count
);

  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(2);

`ifdef ISA_ENC_PSEUDO_LI_EN
  typedef enum logic {S_RUN, S_LI_LO} state_t;
`else
  typedef enum logic {S_RUN} state_t;
`endif

  // Immediate fits an N-bit two's complement field.
  function automatic logic fits_s(input logic [15:0] v, input int n);
    int sv;
    sv = int'($signed(v));
    return (sv >= -(1 << (n - 1))) && (sv < (1 << (n - 1)));
  endfunction

  // Immediate fits an N-bit unsigned field.
  function automatic logic fits_u(input logic [15:0] v, input int n);
    return int'(v) < (1 << n);
  endfunction

  state_t            r_state;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] r_wr_ptr;     // address the next word will be written to
  logic [15:0]       r_mem_wdata;
  logic              r_err_illegal;
  logic              r_err_range;
  logic [15:0]       r_word_count;
`ifdef ISA_ENC_PSEUDO_LI_EN
  logic [15:0]       r_li_word;    // pending LL half of an LI
`endif

  logic              w_accept;
  logic [15:0]       w_enc_word;
  logic              w_enc_legal;
  logic              w_enc_in_range;
  logic              w_enc_li;
  logic [15:0]       w_li_lo_word;
  logic              w_wr_en;
  logic [15:0]       w_wr_data;
  logic              w_go_li;

  // start takes priority over in_valid, so ready drops combinationally.
  assign in_ready = rst_n && !start && (r_state == S_RUN);
  assign w_accept = in_valid && in_ready;

  // Opcode decode and field packing.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    w_enc_word     = 16'h0000;
    w_enc_legal    = 1'b1;
    w_enc_in_range = 1'b1;
    w_enc_li       = 1'b0;
    w_li_lo_word   = 16'h0000;
    if (in_op < 6'd8) begin
      w_enc_word = {4'b0000, in_op[2:0], in_ra, in_rb, in_rc};
    end else begin
      case (in_op)
        6'd8: begin
          w_enc_word     = {5'b00010, in_ra, in_imm[7:0]};
          w_enc_in_range = fits_u(in_imm, 8);
        end
        6'd9: begin
          w_enc_word     = {5'b00011, in_ra, in_imm[7:0]};
          w_enc_in_range = fits_u(in_imm, 8);
        end
        6'd10: begin
          w_enc_word     = {4'b0010, in_ra, in_rb, in_imm[5:0]};
          w_enc_in_range = fits_s(in_imm, 6);
        end
        6'd11: begin
          w_enc_word     = {5'b00110, in_imm[4:0], in_ra, in_rb};
          w_enc_in_range = fits_u(in_imm, 5);
        end
        6'd12: w_enc_word = 16'h3800;
        6'd13: begin
          w_enc_word     = {6'b001111, in_imm[9:0]};
          w_enc_in_range = fits_s(in_imm, 10);
        end
        6'd14: begin
          w_enc_word     = {4'b0100, in_ra, in_imm[8:0]};
          w_enc_in_range = fits_s(in_imm, 9);
        end
        6'd15: begin
          w_enc_word     = {4'b0101, in_ra, in_imm[8:0]};
          w_enc_in_range = fits_s(in_imm, 9);
        end
        6'd16: w_enc_word = {10'b0111000010, in_ra, in_rb};
        6'd17: w_enc_word = {10'b0111000011, in_ra, in_rb};
        6'd18: w_enc_word = {13'b0111000000000, in_ra};
        6'd19: w_enc_word = {13'b0111000000001, in_ra};
        6'd20: w_enc_word = {6'b011101, 7'b0000000, in_ra};  // GETSP
        6'd21: w_enc_word = {6'b011101, 7'b0100000, in_ra};  // CHGSP
        6'd22: w_enc_word = {6'b011101, 7'b0100001, in_ra};  // SETSP
        6'd23: w_enc_word = {6'b011101, 7'b1000000, in_ra};  // GETPC
        6'd24: w_enc_word = {6'b011101, 7'b1100000, in_ra};  // CHGPC
        6'd25: w_enc_word = {6'b011101, 7'b1110000, in_ra};  // SETPC
        6'd26: begin
          w_enc_word     = {6'b011110, in_imm[9:0]};
          w_enc_in_range = fits_s(in_imm, 10);
        end
        6'd27: begin
          w_enc_word     = {6'b011111, in_imm[9:0]};
          w_enc_in_range = fits_s(in_imm, 10);
        end
        6'd28, 6'd29, 6'd30, 6'd31: begin
          // EQ/NEQ/LT/GEQ: top bits are 1 followed by the low two op bits.
          w_enc_word     = {1'b1, in_op[1:0], in_ra, in_rb, in_imm[6:0]};
          w_enc_in_range = fits_s(in_imm, 7);
        end
`ifdef ISA_ENC_PSEUDO_LI_EN
        6'd32: begin
          // LI: LU with the high byte now, LL with the low byte next cycle.
          w_enc_word   = {5'b00010, in_ra, in_imm[15:8]};
          w_li_lo_word = {5'b00011, in_ra, in_imm[7:0]};
          w_enc_li     = 1'b1;
        end
`endif
        default: w_enc_legal = 1'b0;
      endcase
    end
  end

  // Select what (if anything) gets written at the next edge.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_data = w_enc_word;
    w_go_li   = 1'b0;
`ifdef ISA_ENC_PSEUDO_LI_EN
    if (r_state == S_LI_LO) begin
      w_wr_en   = 1'b1;
      w_wr_data = r_li_word;
    end else
`endif
    if (w_accept && w_enc_legal && w_enc_in_range) begin
      w_wr_en = 1'b1;
      w_go_li = w_enc_li;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state       <= S_RUN;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= START;
      r_wr_ptr      <= START;
      r_mem_wdata   <= 16'h0000;
      r_err_illegal <= 1'b0;
      r_err_range   <= 1'b0;
      r_word_count  <= 16'h0000;
`ifdef ISA_ENC_PSEUDO_LI_EN
      r_li_word     <= 16'h0000;
`endif
    end else if (start) begin
      // Also aborts a pending LL word.
      r_state       <= S_RUN;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= START;
      r_wr_ptr      <= START;
      r_err_illegal <= 1'b0;
      r_err_range   <= 1'b0;
      r_word_count  <= 16'h0000;
    end else begin
      r_mem_we <= w_wr_en;
      if (w_wr_en) begin
        r_mem_addr  <= r_wr_ptr;
        r_wr_ptr    <= r_wr_ptr + STEP;
        r_mem_wdata <= w_wr_data;
        if (r_word_count != 16'hFFFF) r_word_count <= r_word_count + 16'd1;
      end
      // Rejected requests are still consumed; only the sticky flag records them.
      if (w_accept && !w_enc_legal)                  r_err_illegal <= 1'b1;
      if (w_accept && w_enc_legal && !w_enc_in_range) r_err_range  <= 1'b1;
`ifdef ISA_ENC_PSEUDO_LI_EN
      case (r_state)
        S_RUN: begin
          if (w_go_li) begin
            r_state   <= S_LI_LO;
            r_li_word <= w_li_lo_word;
          end
        end
        S_LI_LO: r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
`endif
    end
  end

  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign err_illegal = r_err_illegal;
  assign err_range   = r_err_range;
  assign word_count  = r_word_count;

endmodule

// File: tb/tb_isa_word_encoder.sv
// ---------------------------------------------------------------------------
// tb_isa_word_encoder
//
// Directed bench for isa_word_encoder. Instance u_dut uses default parameters;
// u_dut_b (ADDR_W=4, START_ADDR=14) shares the stimulus and is used to check
// address wrap. Expected words are hand-encoded from the instruction format.
// LI expectations follow the ISA_ENC_PSEUDO_LI_EN macro.
// ---------------------------------------------------------------------------
module tb_isa_word_encoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [5:0]  in_op;
  logic [2:0]  in_ra;
  logic [2:0]  in_rb;
  logic [2:0]  in_rc;
  logic [15:0] in_imm;

  logic        in_ready,    b_in_ready;
  logic        mem_we,      b_mem_we;
  logic [7:0]  mem_addr;
  logic [3:0]  b_mem_addr;
  logic [15:0] mem_wdata,   b_mem_wdata;
  logic        err_illegal, b_err_illegal;
  logic        err_range,   b_err_range;
  logic [15:0] word_count,  b_word_count;

  int n_tests = 0;
  int n_fail  = 0;

  isa_word_encoder #(.ADDR_W(8), .START_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb),
    .in_rc(in_rc), .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .err_illegal(err_illegal), .err_range(err_range),
    .word_count(word_count)
  );

  isa_word_encoder #(.ADDR_W(4), .START_ADDR(14)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb),
    .in_rc(in_rc), .in_imm(in_imm), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .err_illegal(b_err_illegal),
    .err_range(b_err_range), .word_count(b_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [5:0] op, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [2:0] rc, input logic [15:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    in_ra    = ra;
    in_rb    = rb;
    in_rc    = rc;
    in_imm   = imm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Present one request, take the accept edge, and check the written word.
  task automatic req_chk(input string tag, input logic [5:0] op, input logic [2:0] ra,
                         input logic [2:0] rb, input logic [2:0] rc, input logic [15:0] imm,
                         input logic [7:0] exp_addr, input logic [15:0] exp_word);
    set_req(op, ra, rb, rc, imm);
    tick();
    check({tag, "_we"},   32'(mem_we),    32'd1);
    check({tag, "_addr"}, 32'(mem_addr),  32'(exp_addr));
    check({tag, "_data"}, 32'(mem_wdata), 32'(exp_word));
  endtask

  task automatic do_start();
    idle();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_op    = 6'd0;
    in_ra    = 3'd0;
    in_rb    = 3'd0;
    in_rc    = 3'd0;
    in_imm   = 16'h0000;
    tick();
    tick();

    // Reset state.
    check("rst_ready",   32'(in_ready),    32'd0);
    check("rst_we",      32'(mem_we),      32'd0);
    check("rst_addr",    32'(mem_addr),    32'd0);
    check("rst_wdata",   32'(mem_wdata),   32'd0);
    check("rst_ill",     32'(err_illegal), 32'd0);
    check("rst_rng",     32'(err_range),   32'd0);
    check("rst_count",   32'(word_count),  32'd0);
    check("rst_b_addr",  32'(b_mem_addr),  32'd14);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Back-to-back RETURN: A writes 0,2; B writes 14 then wraps to 0.
    req_chk("ret0", 6'd12, 3'd0, 3'd0, 3'd0, 16'h0000, 8'h00, 16'h3800);
    check("ret0_b_we",   32'(b_mem_we),    32'd1);
    check("ret0_b_addr", 32'(b_mem_addr),  32'd14);
    check("ret0_b_data", 32'(b_mem_wdata), 32'h3800);
    req_chk("ret1", 6'd12, 3'd0, 3'd0, 3'd0, 16'h0000, 8'h02, 16'h3800);
    check("ret1_b_addr", 32'(b_mem_addr),  32'd0);
    check("ret1_b_data", 32'(b_mem_wdata), 32'h3800);
    check("ret1_count",  32'(word_count),  32'd2);
    check("ret1_b_count",32'(b_word_count),32'd2);
    idle();
    tick();
    check("idle_we", 32'(mem_we), 32'd0);

    // start wins over a valid request in the same cycle.
    set_req(6'd3, 3'd1, 3'd2, 3'd3, 16'h0000);
    start = 1'b1;
    #1;
    check("start_ready", 32'(in_ready), 32'd0);
    tick();
    start = 1'b0;
    check("start_we",    32'(mem_we),     32'd0);
    check("start_addr",  32'(mem_addr),   32'd0);
    check("start_count", 32'(word_count), 32'd0);

    // ALU op 3, request still held from above.
    req_chk("alu3", 6'd3, 3'd1, 3'd2, 3'd3, 16'h0000, 8'h00, 16'h0653);
    check("alu3_count", 32'(word_count), 32'd1);

    // ADDI imm=40 is outside s6: dropped, flag set, pointer unchanged.
    set_req(6'd10, 3'd0, 3'd0, 3'd0, 16'd40);
    tick();
    check("addi_rng_we",    32'(mem_we),     32'd0);
    check("addi_rng_flag",  32'(err_range),  32'd1);
    check("addi_rng_count", 32'(word_count), 32'd1);
    req_chk("alu0", 6'd0, 3'd7, 3'd7, 3'd7, 16'h0000, 8'h02, 16'h01FF);

    // Throughput burst of assorted encodings.
    req_chk("eq",    6'd28, 3'd1, 3'd2, 3'd0, 16'hFFFF, 8'h04, 16'h857F);
    req_chk("jump",  6'd13, 3'd0, 3'd0, 3'd0, 16'hFE00, 8'h06, 16'h3E00);
    req_chk("shift", 6'd11, 3'd5, 3'd6, 3'd0, 16'd31,   8'h08, 16'h37EE);
    req_chk("chgpc", 6'd24, 3'd4, 3'd0, 3'd0, 16'h0000, 8'h0A, 16'h7704);
    req_chk("str",   6'd16, 3'd3, 3'd5, 3'd0, 16'h0000, 8'h0C, 16'h709D);
    check("burst_count", 32'(word_count), 32'd7);

    // start clears errors and count; JUMP +512 overflows s10.
    do_start();
    check("clr_rng",   32'(err_range),  32'd0);
    check("clr_count", 32'(word_count), 32'd0);
    set_req(6'd13, 3'd0, 3'd0, 3'd0, 16'd512);
    tick();
    check("jump_rng_we",   32'(mem_we),    32'd0);
    check("jump_rng_flag", 32'(err_range), 32'd1);
    req_chk("ret_after_rng", 6'd12, 3'd0, 3'd0, 3'd0, 16'h0000, 8'h00, 16'h3800);

    // Illegal opcode.
    set_req(6'd40, 3'd0, 3'd0, 3'd0, 16'h0000);
    tick();
    idle();
    check("ill_flag",  32'(err_illegal), 32'd1);
    check("ill_we",    32'(mem_we),      32'd0);
    check("ill_count", 32'(word_count),  32'd1);
    do_start();
    check("ill_clr", 32'(err_illegal), 32'd0);

    // LI ra=2 imm=0xBEEF.
    set_req(6'd32, 3'd2, 3'd0, 3'd0, 16'hBEEF);
    tick();
    idle();
`ifdef ISA_ENC_PSEUDO_LI_EN
    check("li_hi_we",    32'(mem_we),    32'd1);
    check("li_hi_addr",  32'(mem_addr),  32'd0);
    check("li_hi_data",  32'(mem_wdata), 32'h12BE);
    check("li_hi_ready", 32'(in_ready),  32'd0);
    tick();
    check("li_lo_we",    32'(mem_we),     32'd1);
    check("li_lo_addr",  32'(mem_addr),   32'd2);
    check("li_lo_data",  32'(mem_wdata),  32'h1AEF);
    check("li_lo_ready", 32'(in_ready),   32'd1);
    check("li_count",    32'(word_count), 32'd2);
`else
    check("li_off_we",    32'(mem_we),      32'd0);
    check("li_off_ill",   32'(err_illegal), 32'd1);
    check("li_off_count", 32'(word_count),  32'd0);
    tick();
    check("li_off_we2",   32'(mem_we),      32'd0);
`endif

    // start during the second LI cycle aborts the LL word and clears state.
    do_start();
    set_req(6'd63, 3'd0, 3'd0, 3'd0, 16'h0000);
    tick();
    idle();
    check("ill63_flag", 32'(err_illegal), 32'd1);
`ifdef ISA_ENC_PSEUDO_LI_EN
    req_chk("li_abort_hi", 6'd32, 3'd3, 3'd0, 3'd0, 16'h1234, 8'h00, 16'h1312);
    idle();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_we",    32'(mem_we),      32'd0);
    check("abort_addr",  32'(mem_addr),    32'd0);
    check("abort_count", 32'(word_count),  32'd0);
    check("abort_ill",   32'(err_illegal), 32'd0);
    check("abort_ready", 32'(in_ready),    32'd1);
    tick();
    check("abort_no_ll", 32'(mem_we), 32'd0);

    // Reset during the second LI cycle drops the LL word.
    req_chk("li_rst_hi", 6'd32, 3'd1, 3'd0, 3'd0, 16'h00FF, 8'h00, 16'h1100);
    idle();
    rst_n = 1'b0;
    tick();
    check("li_rst_we",    32'(mem_we),     32'd0);
    check("li_rst_ready", 32'(in_ready),   32'd0);
    check("li_rst_count", 32'(word_count), 32'd0);
    rst_n = 1'b1;
    tick();
    check("li_rst_no_ll", 32'(mem_we), 32'd0);
`else
    do_start();
    check("start_clr_ill",   32'(err_illegal), 32'd0);
    check("start_clr_count", 32'(word_count),  32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/isa_word_encoder.md
# isa_word_encoder

- Sequential instruction encoder/loader: the write side of the 16-bit Unicycle instruction format.
- Accepts symbolic instructions (opcode index, register fields, immediate) over a valid/ready handshake, range-checks operands and packs them into 16-bit instruction words.
- Writes each word into instruction memory at a byte address that advances by 2.
- Used by the boot/debug path to load programs that the control decoder later executes.

## Interface

Parameters:
- ADDR_W, 8: instruction-memory byte-address width.
- START_ADDR, 0: address loaded on reset and on start; must be even.

Ports (synchronous active-low reset `rst_n`; one clock `clk`):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  restart load: address to START_ADDR, clear errors and count
- in_valid  in  1  instruction request valid
- in_ready  out  1  request accepted on edge where in_valid && in_ready
- in_op  in  6  opcode index (see Operation)
- in_ra  in  3  first register field (dest / source)
- in_rb  in  3  second register field
- in_rc  in  3  third register field
- in_imm  in  16  immediate, two's complement or unsigned per op
- mem_we  out  1  one-cycle write strobe per word
- mem_addr  out  ADDR_W  byte address of mem_wdata
- mem_wdata  out  16  encoded instruction word
- err_illegal  out  1  sticky: illegal in_op accepted
- err_range  out  1  sticky: immediate out of field range
- word_count  out  16  words written since reset/start, saturating at 0xFFFF

## Operation

Encodings (bit ranges inclusive):
- ops 0-7 ALU: 0000, [11:9]=op, ra[8:6], rb[5:3], rc[2:0].
- 8 LU: 00010, ra[10:8], imm u8[7:0].
- 9 LL: 00011, ra[10:8], imm u8[7:0].
- 10 ADDI: 0010, ra[11:9], rb[8:6], s6[5:0].
- 11 SHIFT: 00110, u5[10:6], ra[5:3], rb[2:0].
- 12 RETURN: 0x3800.
- 13 JUMP: 001111, s10[9:0].
- 14 STRSP: 0100, ra[11:9], s9[8:0].
- 15 RTVSP: 0101, ra[11:9], s9[8:0].
- 16 STR: 011100 0010, ra[5:3], rb[2:0].
- 17 RTV: 011100 0011, ra[5:3], rb[2:0].
- 18 READ: 011100 0000 000, ra[2:0].
- 19 WRITE: 011100 0000 001, ra[2:0].
- 20-25: 011101, [9:3] = GETSP 0000000, CHGSP 0100000, SETSP 0100001, GETPC 1000000, CHGPC 1100000, SETPC 1110000; ra[2:0].
- 26 CHGSPI: 011110, s10[9:0].
- 27 CHGPCI: 011111, s10[9:0].
- 28-31 EQ/NEQ/LT/GEQ: [15:13] = 100/101/110/111, ra[12:10], rb[9:7], s7[6:0].
- 32: LI pseudo-op (see Configuration).
- 33-63: illegal.

Checks and errors:
- Signed fields (sN) require in_imm within -2^(N-1)..2^(N-1)-1; unsigned fields (uN) require in_imm < 2^N. Unused fields ignored.
- Range failure: set err_range, write nothing, address and count unchanged, request still consumed.
- Illegal op: set err_illegal, same drop behaviour.

FSM states:
- RUN: in_ready=1 unless start. Accepted legal op registers its word to mem_* next cycle.
- LI_LO: in_ready=0; emits second LI word, then returns to RUN.

Address and count:
- Address advances by 2 after every write, wrapping modulo 2^ADDR_W.
- word_count increments per write.

## Timing

- Reset values: in_ready=0 during reset then 1; mem_we=0, mem_addr=START_ADDR, mem_wdata=0, err_*=0, word_count=0, state RUN.
- Latency: request accepted at edge N produces mem_we=1 in cycle N+1. Throughput is one word per cycle.
- LI: LU word in N+1, LL word in N+2 at address+2; in_ready low during cycle N+1.
- start: priority over in_valid (no accept that cycle). In LI_LO, start aborts the pending LL word.
- Reset mid-LI drops the LL word; mem_we=0 in the cycle after reset is asserted.

## Configuration

- ISA_ENC_PSEUDO_LI_EN defined: op 32 expands to LU ra,in_imm[15:8] then LL ra,in_imm[7:0]. Any 16-bit in_imm is in range.
- Macro undefined: op 32 is illegal (err_illegal, no write) and state LI_LO does not exist.

## Test plan

- ALU op 3, ra=1 rb=2 rc=3 after reset -> mem_we at addr 0x00, wdata 0x0653; word_count=1.
- LI ra=2 imm=0xBEEF (macro on) -> 0x12BE at 0x00, 0x1AEF at 0x02, in_ready low one cycle; macro off -> err_illegal=1, no write.
- ADDI imm=40 -> err_range=1, no mem_we, next valid op writes at unchanged address.
- EQ ra=1 rb=2 imm=-1 -> wdata 0x857F; JUMP imm=-512 -> 0x3E00; JUMP imm=512 -> err_range.
- ADDR_W=4, START_ADDR=14: two back-to-back RETURN -> writes at 14 then 0, both 0x3800.
- start asserted while in LI_LO -> LL suppressed, mem_addr=START_ADDR, err_* and word_count cleared next cycle.
